montgomery_enc: RTL and testbench

- Bit-serial conversion into the Montgomery domain: computes y = x * 2^k mod m by k doubling steps, each followed by a conditional subtraction.
- Counterpart of the multpool Montgomery reduction block, which strips 2^k. Operands enter the reduction-based multiply datapath through this block.
- Same start-pulse / done-pulse handshake as the other multpool engines.

---
 rtl/montgomery_enc_if.sv | 22 ++
 rtl/montgomery_enc.sv | 81 ++++++++
 tb/tb_montgomery_enc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/montgomery_enc_if.sv
// Start/done handshake and operand bus for the Montgomery-domain entry converter.
interface montgomery_enc_if #(
  parameter int NBITS = 128
) ();
  logic                     enable_p;
  logic [NBITS-1:0]         x;
  logic [NBITS-1:0]         m;
  logic [$clog2(NBITS):0]   m_size;
  logic [NBITS-1:0]         y;
  logic                     busy;
  logic                     done_irq_p;

  modport master (
    output enable_p, x, m, m_size,
    input  y, busy, done_irq_p
  );

  modport slave (
    input  enable_p, x, m, m_size,
    output y, busy, done_irq_p
  );
endinterface

// File: rtl/montgomery_enc.sv
// Bit-serial y = x * 2^k mod m: one pre-reduction, then k double-and-conditionally-subtract steps.
module montgomery_enc #(
  parameter int NBITS = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  montgomery_enc_if.slave bus
);
  localparam int CW = $clog2(NBITS) + 1;

  typedef enum logic [1:0] {IDLE, PRERED, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [NBITS:0]   acc;
  logic [NBITS-1:0] m_l;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    k_clamped;
  logic [NBITS+1:0] dbl_sub;
  logic [NBITS-1:0] y_r;
  logic             done_r;
  logic             busy_c;

  assign k_clamped = (bus.m_size > CW'(NBITS)) ? CW'(NBITS) : bus.m_size;
  // Top bit of 2*acc - m is the borrow: set means 2*acc < m, keep the plain double.
  assign dbl_sub   = {acc, 1'b0} - {2'b00, m_l};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    unique case (state)
      IDLE:   state_nxt = IDLE;
      PRERED: begin
        busy_c    = 1'b1;
        state_nxt = (cnt != '0) ? SHIFT : DONE;
      end
      SHIFT:  begin
        busy_c    = 1'b1;
        state_nxt = (cnt == CW'(1)) ? DONE : SHIFT;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.enable_p) state_nxt = PRERED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      m_l    <= '0;
      cnt    <= '0;
      y_r    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == DONE);
      if (state == DONE) y_r <= acc[NBITS-1:0];
      if (bus.enable_p) begin
        acc <= {1'b0, bus.x};
        m_l <= bus.m;
        cnt <= k_clamped;
      end else begin
        unique case (state)
          PRERED: if (acc >= {1'b0, m_l}) acc <= acc - {1'b0, m_l};
          SHIFT: begin
            acc <= dbl_sub[NBITS+1] ? {acc[NBITS-1:0], 1'b0} : dbl_sub[NBITS:0];
            cnt <= cnt - CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.y          = y_r;
  assign bus.busy       = busy_c;
  assign bus.done_irq_p = done_r;
endmodule

// File: tb/tb_montgomery_enc.sv
// Scoreboard bench for montgomery_enc at NBITS=8 (directed) and NBITS=128 (random).
module tb_montgomery_enc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  montgomery_enc_if #(.NBITS(8))   b8 ();
  montgomery_enc_if #(.NBITS(128)) b128 ();

  montgomery_enc #(.NBITS(8))   dut8   (.clk(clk), .rst_n(rst_n), .bus(b8));
  montgomery_enc #(.NBITS(128)) dut128 (.clk(clk), .rst_n(rst_n), .bus(b128));

  typedef struct {
    logic [127:0] y;
    int           lat;
    int           busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done8    = 0;

  always @(negedge clk) if (b8.done_irq_p) done8++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mod(input logic [127:0] xv, input logic [127:0] mv, input int k);
    logic [263:0] p;
    p = {136'b0, xv} << k;
    return 128'(p % {136'b0, mv});
  endfunction

  // Drives enable_p for one cycle (released by finish_job) and optionally queues the expectation.
  task automatic start(input bit wide, input logic [127:0] xv, input logic [127:0] mv,
                       input int k, input bit push, input logic [127:0] ey);
    int kc;
    @(negedge clk);
    if (wide) begin
      b128.enable_p = 1'b1; b128.x = xv; b128.m = mv; b128.m_size = k[7:0];
      kc = (k > 128) ? 128 : k;
    end else begin
      b8.enable_p = 1'b1; b8.x = xv[7:0]; b8.m = mv[7:0]; b8.m_size = k[3:0];
      kc = (k > 8) ? 8 : k;
    end
    if (push) sb.push_back('{y: ey, lat: kc + 2, busy: kc + 1});
  endtask

  task automatic finish_job(input bit wide, input string tag);
    int   lat, bcyc;
    bit   ok;
    exp_t e;
    lat = 0; bcyc = 0; ok = 0;
    @(negedge clk);
    b8.enable_p = 1'b0; b128.enable_p = 1'b0;
    b8.x = 8'($urandom); b8.m = 8'($urandom); b8.m_size = 4'($urandom);
    b128.x = {$urandom, $urandom, $urandom, $urandom};
    b128.m = {$urandom, $urandom, $urandom, $urandom};
    b128.m_size = 8'($urandom);
    for (int i = 0; i < 300; i++) begin
      if (wide ? b128.done_irq_p : b8.done_irq_p) begin ok = 1; break; end
      if (wide ? b128.busy : b8.busy) bcyc++;
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    if (!ok) begin
      check({tag, " timeout"}, 0, 1);
      return;
    end
    check({tag, " y"}, wide ? b128.y : {120'b0, b8.y}, e.y);
    check({tag, " latency"}, lat, e.lat);
    check({tag, " busy_cycles"}, bcyc, e.busy);
    @(negedge clk);
    check({tag, " done_width"}, wide ? b128.done_irq_p : b8.done_irq_p, 0);
  endtask

  initial begin
    logic [127:0] xv, mv;
    int k, d0;
    b8.enable_p = 1'b0; b8.x = '0; b8.m = '0; b8.m_size = '0;
    b128.enable_p = 1'b0; b128.x = '0; b128.m = '0; b128.m_size = '0;
    repeat (3) @(negedge clk);
    check("reset y8", b8.y, 0);
    check("reset busy8", b8.busy, 0);
    check("reset done8", b8.done_irq_p, 0);
    check("reset y128", b128.y, 0);
    check("reset busy128", b128.busy, 0);
    rst_n = 1'b1;

    start(0, 5, 13, 4, 1, 2);     finish_job(0, "m13_x5_k4");
    start(0, 15, 13, 0, 1, 2);    finish_job(0, "m13_x15_k0");
    start(0, 254, 255, 8, 1, 254); finish_job(0, "m255_x254_k8");
    start(0, 7, 251, 8, 1, 35);   finish_job(0, "m251_x7_k8");
    start(0, 7, 251, 12, 1, 35);  finish_job(0, "clamp_k12");

    // Second enable three cycles into the first job: only the second completes.
    d0 = done8;
    start(0, 5, 13, 4, 0, 0);
    @(negedge clk); b8.enable_p = 1'b0;
    @(negedge clk);
    start(0, 7, 251, 8, 1, 35);   finish_job(0, "abort_restart");
    check("abort done_count", done8 - d0, 1);

    // Reset mid-conversion.
    start(0, 7, 251, 8, 0, 0);
    @(negedge clk); b8.enable_p = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done8;
    rst_n = 1'b0;
    #2;
    check("midrst y", b8.y, 0);
    check("midrst busy", b8.busy, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst no_done", done8 - d0, 0);
    check("midrst idle_busy", b8.busy, 0);
    start(0, 5, 13, 4, 1, 2);     finish_job(0, "after_reset");

    // NBITS=128 corners and random regression.
    mv = '1; xv = mv - 128'd12345;
    start(1, xv, mv, 128, 1, ref_mod(xv, mv, 128)); finish_job(1, "m_all_ones_k128");
    start(1, 1, 2, 128, 1, 0);   finish_job(1, "m2_x1_k128");
    start(1, 1, 2, 0, 1, 1);     finish_job(1, "m2_x1_k0");
    for (int i = 0; i < 40; i++) begin
      mv = {$urandom, $urandom, $urandom, $urandom};
      mv = mv >> $urandom_range(0, 126);
      if (mv < 2) mv = 2;
      xv = {$urandom, $urandom, $urandom, $urandom} % mv;
      k  = (i == 0) ? 128 : int'($urandom_range(0, 128));
      start(1, xv, mv, k, 1, ref_mod(xv, mv, k));
      finish_job(1, $sformatf("rand%0d_k%0d", i, k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
